// File: rtl/vga_cap_pkg.sv
// Shared timing constants, derived frame geometry and FSM state type for
// the VGA capture block.
package vga_cap_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_VIS_LO = DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_H_VIS_HI = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE - 1;
  localparam int DEF_V_VIS_LO = DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_V_VIS_HI = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE - 1;

  typedef enum logic {
    HUNT,
    LOCKED
  } cap_state_t;

  // Position counters stick at all-ones so a missing sync can never alias
  // back into a valid count.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Samples one active-low sync line at pixel rate and reports its falling
// edge on the same pixel-enable cycle that sees the low level.
module vga_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pix_en,
  input  logic sync_in,
  output logic fall
);

  logic sync_q;
  logic sync_d;

  always_comb begin
    sync_d = sync_q;
    if (pix_en) sync_d = sync_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 1'b1;
    else       sync_q <= sync_d;
  end

  assign fall = pix_en & sync_q & ~sync_in;

endmodule

// File: rtl/vga_capture.sv
// VGA sink: recovers pixel coordinates from hsync/vsync, strobes each
// visible pixel, counts good frames and flags line/frame geometry errors.
module vga_capture
  import vga_cap_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [2:0]  pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        sync_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_LO = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_VIS_HI = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_VIS_LO = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_VIS_HI = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

  logic hs_fall;
  logic vs_fall;

  vga_sync_edge u_hs_edge (
    .clk     (clk),
    .reset   (reset),
    .pix_en  (pix_en),
    .sync_in (hsync),
    .fall    (hs_fall)
  );

  vga_sync_edge u_vs_edge (
    .clk     (clk),
    .reset   (reset),
    .pix_en  (pix_en),
    .sync_in (vsync),
    .fall    (vs_fall)
  );

  cap_state_t  state_q, state_d;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0]  hcnt_cur, vcnt_cur;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        pix_valid_q, pix_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        sync_err_q, sync_err_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [8:0]  pix_y_q, pix_y_d;
  logic [2:0]  pix_rgb_q, pix_rgb_d;
  logic        in_window;
  logic        geom_err;
  logic        frame_ok;

  // Position of the pixel being sampled now; a vsync fall wins over an
  // hsync fall, and locking always starts from the origin.
  always_comb begin
    hcnt_cur = hs_fall ? 10'd0 : sat_inc10(hcnt_q);
    vcnt_cur = vcnt_q;
    if (vs_fall) begin
      vcnt_cur = 10'd0;
      if (state_q == HUNT) hcnt_cur = 10'd0;
    end else if (hs_fall) begin
      vcnt_cur = sat_inc10(vcnt_q);
    end
    in_window = (hcnt_cur >= H_VIS_LO) && (hcnt_cur <= H_VIS_HI) &&
                (vcnt_cur >= V_VIS_LO) && (vcnt_cur <= V_VIS_HI);
  end

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    frame_cnt_d  = frame_cnt_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_rgb_d    = pix_rgb_q;
    geom_err     = 1'b0;
    frame_ok     = 1'b0;

    if (pix_en) begin
      hcnt_d = hcnt_cur;
      vcnt_d = vcnt_cur;
      if (state_q == HUNT) begin
        if (vs_fall) state_d = LOCKED;
      end else begin
        if (vs_fall) begin
          if (vcnt_q == V_LAST) frame_ok = 1'b1;
          else                  geom_err = 1'b1;
        end else if (hs_fall && (hcnt_q != H_LAST)) begin
          geom_err = 1'b1;
        end

        if (geom_err) begin
          state_d    = HUNT;
          sync_err_d = 1'b1;
        end else if (in_window) begin
          pix_valid_d = 1'b1;
          pix_x_d     = hcnt_cur - H_VIS_LO;
          pix_y_d     = 9'(vcnt_cur - V_VIS_LO);
          pix_rgb_d   = rgb;
        end

        if (frame_ok) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      frame_cnt_q  <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= '0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      frame_cnt_q  <= frame_cnt_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_rgb_q    <= pix_rgb_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a reduced 25x13 geometry so that
// many complete frames fit in a short run.
module tb_vga_capture;

  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 4;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 8;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_LO     = H_SYNC + H_BP;
  localparam int V_LO     = V_SYNC + V_BP;
  localparam int NSCN     = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [2:0]  pix_rgb;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        sync_err;

  vga_capture #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    gap;
    int    n_lines;
    int    short_line;
    int    short_len;
    int    reset_line;
    int    reset_col;
    bit    marker;
    int    exp_valid;
    int    exp_done;
    int    exp_err;
    int    exp_fcnt;
  } scen_t;

  scen_t scn [NSCN];

  int checks = 0;
  int errors = 0;

  // Reference model: locked flag, previous sync samples, expected outputs.
  bit          m_locked;
  bit          prev_hs;
  bit          prev_vs;
  int          prev_frame_lines;
  int          last_line_len;
  logic        e_valid, e_done, e_err;
  logic [9:0]  e_x;
  logic [8:0]  e_y;
  logic [2:0]  e_rgb;
  logic [15:0] e_fcnt;

  int          n_valid, n_done, n_err;
  bit          seen_first;
  logic [9:0]  first_x, last_x;
  logic [8:0]  first_y, last_y;
  logic [2:0]  first_rgb, last_rgb;

  function automatic scen_t mk(string n, int gap, int lines, int sl, int slen,
                               int rl, int rc, bit mark, int ev, int ed,
                               int ee, int ef);
    scen_t s;
    s.name = n; s.gap = gap; s.n_lines = lines; s.short_line = sl;
    s.short_len = slen; s.reset_line = rl; s.reset_col = rc; s.marker = mark;
    s.exp_valid = ev; s.exp_done = ed; s.exp_err = ee; s.exp_fcnt = ef;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compareOutputs(input string name);
    checks++;
    if ({pix_valid, frame_done, sync_err, pix_x, pix_y, pix_rgb, frame_cnt} !==
        {e_valid, e_done, e_err, e_x, e_y, e_rgb, e_fcnt}) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got v=%b d=%b e=%b x=%0d y=%0d rgb=%0d cnt=%0d, expected v=%b d=%b e=%b x=%0d y=%0d rgb=%0d cnt=%0d",
               name, $time, pix_valid, frame_done, sync_err, pix_x, pix_y,
               pix_rgb, frame_cnt, e_valid, e_done, e_err, e_x, e_y, e_rgb,
               e_fcnt);
    end
  endtask

  task automatic checkOutput();
    compareOutputs("outputs");
    if (pix_valid === 1'b1) begin
      n_valid++;
      if (!seen_first) begin
        seen_first = 1'b1;
        first_x = pix_x; first_y = pix_y; first_rgb = pix_rgb;
      end
      last_x = pix_x; last_y = pix_y; last_rgb = pix_rgb;
    end
    if (frame_done === 1'b1) n_done++;
    if (sync_err === 1'b1) n_err++;
  endtask

  task automatic clear_model();
    m_locked = 1'b0;
    prev_hs  = 1'b1;
    prev_vs  = 1'b1;
    e_valid = 1'b0; e_done = 1'b0; e_err = 1'b0;
    e_x = '0; e_y = '0; e_rgb = '0; e_fcnt = '0;
  endtask

  task automatic applyStimulus(input logic pe, input logic hs, input logic vs,
                               input logic [2:0] c);
    @(negedge clk);
    checkOutput();
    pix_en = pe;
    hsync  = hs;
    vsync  = vs;
    rgb    = c;
    e_valid = 1'b0;
    e_done  = 1'b0;
    e_err   = 1'b0;
  endtask

  // One pixel at stream position (l, col); expectations come from where the
  // generator is in the frame and what the previous line/frame looked like.
  task automatic drive_pixel(input int l, input int col, input int prev_len,
                             input logic [2:0] c, input int gap);
    logic hs, vs;
    bit hs_ev, vs_ev, err, done, nxt, vis;
    hs = (col >= H_SYNC);
    vs = (l >= V_SYNC);
    applyStimulus(1'b1, hs, vs, c);
    hs_ev = prev_hs && !hs;
    vs_ev = prev_vs && !vs;
    prev_hs = hs;
    prev_vs = vs;
    err  = 1'b0;
    done = 1'b0;
    if (m_locked) begin
      if (vs_ev) begin
        if (prev_frame_lines == V_TOTAL) done = 1'b1;
        else                             err  = 1'b1;
      end else if (hs_ev && prev_len != H_TOTAL) begin
        err = 1'b1;
      end
    end
    nxt = err ? 1'b0 : (m_locked || vs_ev);
    vis = nxt && l >= V_LO && l < V_LO + V_ACTIVE &&
          col >= H_LO && col < H_LO + H_ACTIVE;
    m_locked = nxt;
    e_done = done;
    e_err  = err;
    if (done) e_fcnt = e_fcnt + 16'd1;
    if (vis) begin
      e_valid = 1'b1;
      e_x     = 10'(col - H_LO);
      e_y     = 9'(l - V_LO);
      e_rgb   = c;
    end
    for (int g = 1; g < gap; g++) applyStimulus(1'b0, hs, vs, 3'($urandom));
  endtask

  task automatic midReset();
    @(negedge clk);
    checkOutput();
    reset  = 1'b1;
    pix_en = 1'b0;
    clear_model();
    #1;
    compareOutputs("reset_clear");
    @(negedge clk);
    checkOutput();
    reset = 1'b0;
  endtask

  task automatic send_frame(input scen_t s);
    int len, prev_len, gap;
    logic [2:0] c;
    prev_len = last_line_len;
    for (int l = 0; l < s.n_lines; l++) begin
      len = (l == s.short_line) ? s.short_len : H_TOTAL;
      for (int col = 0; col < len; col++) begin
        if (l == s.reset_line && col == s.reset_col) midReset();
        gap = (s.gap < 0) ? int'($urandom_range(1, 4)) : s.gap;
        if (s.marker) c = (l == V_LO && col == H_LO) ? 3'b101 : 3'b000;
        else          c = 3'($urandom);
        drive_pixel(l, col, prev_len, c, gap);
      end
      prev_len = len;
    end
    last_line_len    = prev_len;
    prev_frame_lines = s.n_lines;
  endtask

  initial begin
    // Event counts are those seen while each frame is sent: frame_done and
    // sync_err for a frame boundary land in the frame that starts there.
    scn[0]  = mk("lock",        4, 13, -1,  0, -1,  0, 1'b0, 128, 0, 0, 0);
    scn[1]  = mk("full",        4, 13, -1,  0, -1,  0, 1'b0, 128, 1, 0, 1);
    scn[2]  = mk("short_line",  4, 13,  6, 24, -1,  0, 1'b0,  48, 1, 1, 2);
    scn[3]  = mk("relock",      4, 13, -1,  0, -1,  0, 1'b0, 128, 0, 0, 2);
    scn[4]  = mk("short_frame", 4, 12, -1,  0, -1,  0, 1'b0, 128, 1, 0, 3);
    scn[5]  = mk("after_short", 1, 13, -1,  0, -1,  0, 1'b0,   0, 0, 1, 3);
    scn[6]  = mk("cont_pix_en", 1, 13, -1,  0, -1,  0, 1'b0, 128, 0, 0, 3);
    scn[7]  = mk("random_gap", -1, 13, -1,  0, -1,  0, 1'b0, 128, 1, 0, 4);
    scn[8]  = mk("reset_mid",   4, 13, -1,  0,  6, 10, 1'b0,  35, 1, 0, 0);
    scn[9]  = mk("relock_rst",  4, 13, -1,  0, -1,  0, 1'b0, 128, 0, 0, 0);
    scn[10] = mk("marker",      4, 13, -1,  0, -1,  0, 1'b1, 128, 1, 0, 1);
    scn[11] = mk("final",       2, 13, -1,  0, -1,  0, 1'b0, 128, 1, 0, 2);

    reset  = 1'b1;
    pix_en = 1'b0;
    hsync  = 1'b1;
    vsync  = 1'b1;
    rgb    = 3'b000;
    clear_model();
    prev_frame_lines = 0;
    last_line_len    = H_TOTAL;
    #2;
    compareOutputs("reset_state");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NSCN; i++) begin
      n_valid = 0; n_done = 0; n_err = 0; seen_first = 1'b0;
      send_frame(scn[i]);
      check({scn[i].name, ".pix_valid_count"}, n_valid, scn[i].exp_valid);
      check({scn[i].name, ".frame_done_count"}, n_done, scn[i].exp_done);
      check({scn[i].name, ".sync_err_count"}, n_err, scn[i].exp_err);
      check({scn[i].name, ".frame_cnt"}, int'(frame_cnt), scn[i].exp_fcnt);
      if (scn[i].marker) begin
        check("marker.first_rgb", int'(first_rgb), 5);
        check("marker.first_x", int'(first_x), 0);
        check("marker.first_y", int'(first_y), 0);
        check("marker.last_x", int'(last_x), H_ACTIVE - 1);
        check("marker.last_y", int'(last_y), V_ACTIVE - 1);
        check("marker.last_rgb", int'(last_rgb), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
